booth_r8_seq: RTL and testbench

Parametrised, handshaked, sequential radix-8 Booth multiplier; next generation of the fixed-width 8-bit Booth block. Multiplies two N-bit operands, signed or unsigned selected per operation, retiring 3 multiplier bits per cycle after a one-cycle 3x-multiplicand precompute. Sits beside the existing multiplier as the datapath multiply unit. It adds per-operation signedness, Busy, back-to-back issue and a held Product register.

---
 rtl/booth_r8_seq.sv | 73 +++++++
 tb/tb_booth_r8_seq.sv | 160 ++++++++++++++++
 2 files changed

// File: rtl/booth_r8_seq.sv
// booth_r8_seq: handshaked sequential radix-8 Booth multiplier, signed or unsigned per operation
module booth_r8_seq #(
  parameter int N = 8
) (
  input  logic           Clock,
  input  logic           Resetn,
  input  logic           Start,
  input  logic           Signed,
  input  logic [N-1:0]   Mplier,
  input  logic [N-1:0]   Mcand,
  output logic           Busy,
  output logic           Done,
  output logic [2*N-1:0] Product
);
  localparam int K = (N + 3) / 3;
  localparam int W = 3 * K;
  localparam int MW = 2 * N + 3;
  localparam int CW = $clog2(K);
  typedef enum logic [1:0] {IDLE, PRE, ITER, FIN} state_t;
  state_t state, state_n;
  logic [W:0] mp;
  logic [MW-1:0] m, m3, acc, mag, pp, acc_n;
  logic [CW-1:0] cnt;
  logic [2:0] sum, dmag;
  logic neg, last, load;
  always_comb begin
    sum = {1'b0, mp[2], 1'b0} + {2'b0, mp[1]} + {2'b0, mp[0]};
    neg = mp[3];
    dmag = neg ? 3'd4 - sum : sum;
    mag = dmag == 3'd1 ? m : dmag == 3'd2 ? m << 1 : dmag == 3'd3 ? m3 : dmag == 3'd4 ? m << 2 : '0;
    pp = neg ? -mag : mag;
    acc_n = acc + pp;
    last = cnt == CW'(K - 1);
    load = Start && (state == IDLE || state == FIN);
    state_n = state == IDLE ? (Start ? PRE : IDLE) :
              state == PRE  ? ITER :
              state == ITER ? (last ? FIN : ITER) :
              (Start ? PRE : IDLE);
    Busy = state == PRE || state == ITER;
    Done = state == FIN;
  end
  always_ff @(posedge Clock or negedge Resetn)
    if (!Resetn) state <= IDLE;
    else state <= state_n;
  // the multiplicand and 3M shift left as the multiplier shifts right, so each digit lands at weight 8^i
  always_ff @(posedge Clock or negedge Resetn)
    if (!Resetn) begin
      mp <= '0;
      m <= '0;
      m3 <= '0;
      acc <= '0;
      cnt <= '0;
      Product <= '0;
    end else begin
      if (load) begin
        mp <= {{(W-N){Signed & Mplier[N-1]}}, Mplier, 1'b0};
        m <= {{(N+3){Signed & Mcand[N-1]}}, Mcand};
      end
      if (state == PRE) begin
        m3 <= m + (m << 1);
        acc <= '0;
        cnt <= '0;
      end
      if (state == ITER) begin
        acc <= acc_n;
        cnt <= cnt + CW'(1);
        mp <= mp >> 3;
        m <= m << 3;
        m3 <= m3 << 3;
        if (last) Product <= acc_n[2*N-1:0];
      end
    end
endmodule

// File: tb/tb_booth_r8_seq.sv
// tb_booth_r8_seq: directed checks of booth_r8_seq at N=8 and N=16
module tb_booth_r8_seq;
  logic clk = 0, rst_n = 0;
  logic s8 = 0, sg8 = 0, s16 = 0, sg16 = 0;
  logic [7:0] mp8 = '0, mc8 = '0;
  logic [15:0] mp16 = '0, mc16 = '0;
  logic busy8, done8, busy16, done16;
  logic [15:0] p8;
  logic [31:0] p16;
  int total = 0, passed = 0;

  booth_r8_seq #(.N(8)) dut8 (.Clock(clk), .Resetn(rst_n), .Start(s8), .Signed(sg8), .Mplier(mp8),
    .Mcand(mc8), .Busy(busy8), .Done(done8), .Product(p8));
  booth_r8_seq #(.N(16)) dut16 (.Clock(clk), .Resetn(rst_n), .Start(s16), .Signed(sg16), .Mplier(mp16),
    .Mcand(mc16), .Busy(busy16), .Done(done16), .Product(p16));

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
    $fatal(1, "timeout");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  function automatic logic [31:0] prod(input bit sel);
    return sel ? p16 : {16'b0, p8};
  endfunction

  task automatic start(input bit sel, input bit sg, input logic [15:0] a, input logic [15:0] b);
    if (sel) begin
      s16 = 1; sg16 = sg; mp16 = a; mc16 = b;
    end else begin
      s8 = 1; sg8 = sg; mp8 = a[7:0]; mc8 = b[7:0];
    end
    @(posedge clk);
    #1;
    s8 = 0; s16 = 0;
    mp8 = 8'($urandom); mc8 = 8'($urandom);
    mp16 = 16'($urandom); mc16 = 16'($urandom);
  endtask

  task automatic wait_done(input bit sel, input int first, output int edges, output int busy_n, output bit stable);
    logic [31:0] p0;
    p0 = prod(sel);
    edges = first; busy_n = 0; stable = 1;
    forever begin
      @(negedge clk);
      if (sel ? done16 : done8) break;
      if (prod(sel) !== p0) stable = 0;
      if (sel ? busy16 : busy8) busy_n++;
      if (edges >= 40) break;
      @(posedge clk);
      edges++;
    end
  endtask

  task automatic run(input string tag, input bit sel, input bit sg, input logic [15:0] a,
                     input logic [15:0] b, input logic [31:0] exp, input int exp_edges);
    int e, bn;
    bit st;
    @(negedge clk);
    start(sel, sg, a, b);
    wait_done(sel, 1, e, bn, st);
    check(tag, prod(sel), exp);
    check({tag, " latency"}, e, exp_edges);
  endtask

  initial begin
    int e, bn, extra;
    bit st;
    logic [15:0] a, b;
    int sa, sb;
    longint ua, ub;
    repeat (2) @(negedge clk);
    check("reset busy8", busy8, 0);
    check("reset done8", done8, 0);
    check("reset product8", p8, 0);
    check("reset product16", p16, 0);
    rst_n = 1;
    // -128 x -128: latency, busy window, one-cycle Done
    @(negedge clk);
    start(0, 1, 16'h80, 16'h80);
    wait_done(0, 1, e, bn, st);
    check("s8 -128x-128", p8, 16'h4000);
    check("s8 -128x-128 latency", e, 5);
    check("s8 busy cycles", bn, 4);
    check("busy low in FIN", busy8, 0);
    @(negedge clk);
    check("done one cycle", done8, 0);
    check("idle busy", busy8, 0);
    run("u8 ffxff", 0, 0, 16'hff, 16'hff, 32'hfe01, 5);
    run("s8 -1x-1", 0, 1, 16'hff, 16'hff, 32'h0001, 5);
    // back-to-back issue in the FIN cycle
    @(negedge clk);
    start(0, 1, 16'hff, 16'h7f);
    wait_done(0, 1, e, bn, st);
    check("s8 -1x127", p8, 16'hff81);
    start(0, 0, 16'h00, 16'h5a);
    wait_done(0, 1, e, bn, st);
    check("b2b latency", e, 5);
    check("b2b product held", st, 1);
    check("b2b 0x5a", p8, 16'h0000);
    // Start while busy is ignored
    @(negedge clk);
    start(0, 0, 16'h3, 16'h5);
    s8 = 1; sg8 = 1; mp8 = 8'h7f; mc8 = 8'h7f;
    @(posedge clk);
    @(posedge clk);
    #1 s8 = 0;
    wait_done(0, 3, e, bn, st);
    check("ignore start latency", e, 5);
    check("ignore start 3x5", p8, 16'h000f);
    extra = 0;
    repeat (12) begin
      @(negedge clk);
      if (done8) extra++;
    end
    check("no extra done", extra, 0);
    // asynchronous reset mid-operation
    @(negedge clk);
    start(0, 0, 16'h12, 16'h34);
    @(posedge clk);
    @(posedge clk);
    #1 rst_n = 0; s8 = 1;
    #1;
    check("async reset busy", busy8, 0);
    check("async reset done", done8, 0);
    check("async reset product", p8, 0);
    @(negedge clk);
    @(negedge clk);
    check("reset wins over start", busy8, 0);
    rst_n = 1; s8 = 0;
    run("u8 0x12x0x34", 0, 0, 16'h12, 16'h34, 32'h03a8, 5);
    // N=16
    run("u16 ffffxffff", 1, 0, 16'hffff, 16'hffff, 32'hfffe0001, 8);
    run("s16 min x min", 1, 1, 16'h8000, 16'h8000, 32'h40000000, 8);
    run("s16 max x min", 1, 1, 16'h7fff, 16'h8000, 32'hc0008000, 8);
    for (int i = 0; i < 200; i++) begin
      a = 16'($urandom);
      b = 16'($urandom);
      if (i % 2 == 1) begin
        sa = int'($signed(a));
        sb = int'($signed(b));
        run("s16 sweep", 1, 1, a, b, 32'(sa * sb), 8);
      end else begin
        ua = longint'(a);
        ub = longint'(b);
        run("u16 sweep", 1, 0, a, b, 32'(ua * ub), 8);
      end
    end
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
